// File: rtl/fwd_sel_ctrl.sv
// Forwarding-select generator for the EX-stage operand muxes. It tracks the EX/MEM/WB
// destination tags, computes the A/B selects in ID, registers them into ID/EX and flags load-use stalls.
module fwd_sel_ctrl #(
  parameter int REG_AW = 3,
  parameter int PC_REG = 7,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_wr,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b
);

  localparam logic [SEL_W-1:0] SEL_RF     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM    = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB_ALU = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_WB_LD  = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_HOLD   = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_PC     = SEL_W'(5);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } trk_t;

  trk_t             r_ex, r_mem, r_wb;
  logic [SEL_W-1:0] r_sel_a, r_sel_b;
  logic [SEL_W-1:0] w_sel_a, w_sel_b;
  logic             w_haz_a, w_haz_b;
  logic             w_stall;
  logic             w_bubble;

  // Priority order matters: the youngest producer wins, and the PC alias beats every entry.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                               input logic use_r,
                                               input trk_t ex, input trk_t mem,
                                               input trk_t wb);
    logic [SEL_W-1:0] s;
    s = SEL_RF;
    if (!use_r)                                s = SEL_RF;
    else if (rs == REG_AW'(PC_REG))            s = SEL_PC;
    else if (ex.v && ex.rd == rs)              s = SEL_MEM;
    else if (mem.v && mem.rd == rs)            s = mem.ld ? SEL_WB_LD : SEL_WB_ALU;
    else if (wb.v && wb.rd == rs)              s = SEL_HOLD;
    return s;
  endfunction

  function automatic logic load_use(input logic [REG_AW-1:0] rs, input logic use_r,
                                    input trk_t ex);
    return use_r && (rs != REG_AW'(PC_REG)) && ex.v && ex.ld && (ex.rd == rs);
  endfunction

  always_comb begin
    w_sel_a  = fwd_sel(id_rs_a, id_use_a, r_ex, r_mem, r_wb);
    w_sel_b  = fwd_sel(id_rs_b, id_use_b, r_ex, r_mem, r_wb);
    w_haz_a  = load_use(id_rs_a, id_use_a, r_ex);
    w_haz_b  = load_use(id_rs_b, id_use_b, r_ex);
    w_stall  = ~reset & id_valid & ~flush & (w_haz_a | w_haz_b);
    w_bubble = w_stall | flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      r_ex.rd <= id_rd;
      r_ex.ld <= id_is_load;
      if (w_bubble) begin
        r_ex.v  <= 1'b0;
        r_sel_a <= SEL_RF;
        r_sel_b <= SEL_RF;
      end else begin
        r_ex.v  <= id_valid & id_rd_wr;
        r_sel_a <= id_valid ? w_sel_a : SEL_RF;
        r_sel_b <= id_valid ? w_sel_b : SEL_RF;
      end
    end
  end

  assign stall = w_stall;
  assign sel_a = r_sel_a;
  assign sel_b = r_sel_b;

endmodule
